// File: rtl/cpx_accum_dump.sv
// cpx_accum_dump
//   Integrate-and-dump for a complex sample stream. Sums acc_len accepted
//   I/Q samples and presents each completed sum as one result on a
//   valid/ready output. The block keeps accumulating while a result is
//   waiting, and stalls only on the sample that would overwrite it.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   m_axis_tvalid  upstream sample valid
//   i, q           signed input samples (i_bits / q_bits)
//   s_axis_tready  sample can be accepted this cycle (combinational)
//   m_axis_tready  downstream ready for a dump result
//   s_axis_tvalid  dump result valid
//   acc_i, acc_q   signed dump result (acc_bits), wraps on overflow
module cpx_accum_dump #(
    parameter int i_bits   = 24,
    parameter int q_bits   = 24,
    parameter int acc_len  = 64,
    parameter int acc_bits = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       m_axis_tvalid,
    input  logic signed [i_bits-1:0]   i,
    input  logic signed [q_bits-1:0]   q,
    output logic                       s_axis_tready,
    input  logic                       m_axis_tready,
    output logic                       s_axis_tvalid,
    output logic signed [acc_bits-1:0] acc_i,
    output logic signed [acc_bits-1:0] acc_q
);

    localparam int              CNT_W    = (acc_len > 1) ? $clog2(acc_len) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(acc_len - 1);

    logic [CNT_W-1:0]           count_q, count_d;
    logic signed [acc_bits-1:0] sum_i_q, sum_i_d;
    logic signed [acc_bits-1:0] sum_q_q, sum_q_d;
    logic signed [acc_bits-1:0] acc_i_q, acc_i_d;
    logic signed [acc_bits-1:0] acc_q_q, acc_q_d;
    logic                       valid_q, valid_d;

    logic                       at_last;
    logic                       accept;
    logic                       dump;
    logic                       out_accept;
    logic signed [acc_bits-1:0] i_ext, q_ext;
    logic signed [acc_bits-1:0] tot_i, tot_q;

    // Size casts of signed operands sign-extend.
    assign i_ext = acc_bits'(i);
    assign q_ext = acc_bits'(q);
    assign tot_i = sum_i_q + i_ext;
    assign tot_q = sum_q_q + q_ext;

    assign at_last = (count_q == CNT_LAST);

    // Only the final sample of a block is held off, and only while the
    // previous result is still unconsumed and not being taken this cycle.
    assign s_axis_tready = rst_n & ~(at_last & valid_q & ~m_axis_tready);

    assign accept     = m_axis_tvalid & s_axis_tready;
    assign dump       = accept & at_last;
    assign out_accept = valid_q & m_axis_tready;

    always_comb begin
        count_d = count_q;
        sum_i_d = sum_i_q;
        sum_q_d = sum_q_q;
        acc_i_d = acc_i_q;
        acc_q_d = acc_q_q;
        valid_d = valid_q;

        if (out_accept) begin
            valid_d = 1'b0;
        end

        if (accept) begin
            if (at_last) begin
                acc_i_d = tot_i;
                acc_q_d = tot_q;
                sum_i_d = '0;
                sum_q_d = '0;
                count_d = '0;
                // A dump in the same cycle as an out-accept keeps valid high.
                valid_d = 1'b1;
            end else begin
                sum_i_d = tot_i;
                sum_q_d = tot_q;
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            sum_i_q <= '0;
            sum_q_q <= '0;
            acc_i_q <= '0;
            acc_q_q <= '0;
            valid_q <= 1'b0;
        end else begin
            count_q <= count_d;
            sum_i_q <= sum_i_d;
            sum_q_q <= sum_q_d;
            acc_i_q <= acc_i_d;
            acc_q_q <= acc_q_d;
            valid_q <= valid_d;
        end
    end

    assign s_axis_tvalid = valid_q;
    assign acc_i         = acc_i_q;
    assign acc_q         = acc_q_q;

endmodule
